// File: rtl/adder_accum_ctrl.sv
// adder_accum_ctrl: sequences a job of `len` signed 8-bit operands through a
// single adder8 instance. It returns the accumulated sum and a sticky signed
// overflow flag over a valid/ready result stream.

// adder8: 8-bit signed adder with a signed-overflow indication.
module adder8 (
  input  logic signed [7:0] a,
  input  logic signed [7:0] b,
  output logic signed [7:0] sum,
  output logic              ovf
);

  // Overflow when both operands share a sign and the result sign differs.
  always_comb begin
    sum = a + b;
    ovf = (a[7] == b[7]) && (sum[7] != a[7]);
  end

endmodule

module adder_accum_ctrl #(
  parameter int COUNT_W  = 4,
  parameter int SATURATE = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [COUNT_W-1:0] len,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [7:0]         out_sum,
  output logic               out_ovf,
  input  logic               out_ready,
  output logic               busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic signed [7:0]  acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  logic signed [7:0]  operand;
  logic signed [7:0]  raw_sum;
  logic               add_ovf;

  assign operand = $signed(in_data);

  adder8 u_adder8 (
    .a   (acc_q),
    .b   (operand),
    .sum (raw_sum),
    .ovf (add_ovf)
  );

  // Choose between the wrapped adder result and the clamped rail on overflow.
  // The rail follows the operand sign. On overflow the accumulator and the
  // operand have the same sign, so either could select it.
  function automatic logic signed [7:0] sat_result(
    input logic signed [7:0] raw,
    input logic              ovf_now,
    input logic              neg_operand
  );
    if ((SATURATE != 0) && ovf_now) begin
      return neg_operand ? 8'sh80 : 8'sh7F;
    end
    return raw;
  endfunction

  // Next-state and datapath update; every register holds unless its state acts.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d   = len;
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = (len == '0) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        // in_ready is high throughout ACCUM, so in_valid alone marks a handshake.
        if (in_valid) begin
          acc_d = sat_result(raw_sum, add_ovf, operand[7]);
          ovf_d = ovf_q | add_ovf;
          cnt_d = cnt_q - COUNT_W'(1);
          if (cnt_q == COUNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; asynchronous reset discards any job in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs come straight from registers or from a state decode, never from inputs.
  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_adder_accum_ctrl.sv
// Bench for adder_accum_ctrl: a wrapping instance and a saturating instance
// share the same stimulus and are checked against an integer reference model.
module tb_adder_accum_ctrl;

  localparam int COUNT_W = 4;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [COUNT_W-1:0] len = '0;
  logic               in_valid = 1'b0;
  logic [7:0]         in_data = '0;
  logic               out_ready = 1'b0;

  logic               in_ready0, out_valid0, out_ovf0, busy0;
  logic [7:0]         out_sum0;
  logic               in_ready1, out_valid1, out_ovf1, busy1;
  logic [7:0]         out_sum1;

  int checks = 0;
  int failures = 0;

  int op_buf[16];
  bit vpat[$];

  always #5 clock = ~clock;

  adder_accum_ctrl #(.COUNT_W(COUNT_W), .SATURATE(0)) u_wrap (
    .clock(clock), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
    .out_valid(out_valid0), .out_sum(out_sum0), .out_ovf(out_ovf0),
    .out_ready(out_ready), .busy(busy0)
  );

  adder_accum_ctrl #(.COUNT_W(COUNT_W), .SATURATE(1)) u_sat (
    .clock(clock), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_sum(out_sum1), .out_ovf(out_ovf1),
    .out_ready(out_ready), .busy(busy1)
  );

  // Reference: exact integer sums. Any step leaving [-128,127] is an overflow;
  // the result then either wraps modulo 256 or clamps to the rail.
  function automatic void model(input int n, input bit sat,
                                output logic [7:0] sum, output bit ovf);
    int acc = 0;
    int s;
    ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = acc + op_buf[i];
      if (s > 127 || s < -128) begin
        ovf = 1'b1;
        if (sat) acc = (s > 127) ? 127 : -128;
        else     acc = (s > 127) ? s - 256 : s + 256;
      end else begin
        acc = s;
      end
    end
    sum = acc[7:0];
  endfunction

  // Runs one job of n operands from op_buf. bubble_pct is the chance that a
  // cycle carries no operand. hold is how many cycles out_ready stays low.
  // noise drives spurious start/len values while the job is in flight.
  task automatic run_job(input string name, input int n, input int bubble_pct,
                         input int hold, input bit noise);
    int idx = 0;
    int cyc = 0;
    bit v;
    logic [7:0] e_sum0, e_sum1;
    bit e_ovf0, e_ovf1;
    model(n, 1'b0, e_sum0, e_ovf0);
    model(n, 1'b1, e_sum1, e_ovf1);

    @(negedge clock);
    start = 1'b1;
    len = n[COUNT_W-1:0];
    in_valid = 1'b0;
    out_ready = (hold == 0);
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;

    while (idx < n && cyc < 200) begin
      checks++;
      if ({in_ready0, in_ready1, out_valid0, out_valid1, busy0, busy1} !== 6'b110011) begin
        failures++;
        $display("FAIL %s accum_ctrl cyc=%0d: got rdy/vld/busy=%b want 110011", name, cyc,
                 {in_ready0, in_ready1, out_valid0, out_valid1, busy0, busy1});
      end
      if (vpat.size() > 0) v = vpat.pop_front();
      else                 v = ($urandom_range(99) >= bubble_pct);
      in_valid = v;
      in_data = v ? op_buf[idx][7:0] : 8'($urandom);
      if (noise) begin
        start = 1'($urandom);
        len = COUNT_W'($urandom);
      end
      @(posedge clock);
      if (v) idx++;
      cyc++;
      @(negedge clock);
    end
    in_valid = 1'b0;
    start = 1'b0;

    checks++;
    if (cyc >= 200) begin
      failures++;
      $display("FAIL %s timeout: consumed %0d operands, want %0d", name, idx, n);
    end

    checks++;
    if ({out_valid0, out_valid1, in_ready0, in_ready1, busy0, busy1} !== 6'b110011) begin
      failures++;
      $display("FAIL %s done_ctrl: got vld/rdy/busy=%b want 110011", name,
               {out_valid0, out_valid1, in_ready0, in_ready1, busy0, busy1});
    end
    checks++;
    if (out_sum0 !== e_sum0 || out_ovf0 !== e_ovf0) begin
      failures++;
      $display("FAIL %s wrap_result: got sum=%0d ovf=%b want sum=%0d ovf=%b", name,
               $signed(out_sum0), out_ovf0, $signed(e_sum0), e_ovf0);
    end
    checks++;
    if (out_sum1 !== e_sum1 || out_ovf1 !== e_ovf1) begin
      failures++;
      $display("FAIL %s sat_result: got sum=%0d ovf=%b want sum=%0d ovf=%b", name,
               $signed(out_sum1), out_ovf1, $signed(e_sum1), e_ovf1);
    end

    for (int h = 0; h < hold; h++) begin
      if (noise) begin
        start = 1'($urandom);
        len = COUNT_W'($urandom);
      end
      @(posedge clock);
      @(negedge clock);
      checks++;
      if (out_valid0 !== 1'b1 || out_valid1 !== 1'b1 || out_sum0 !== e_sum0 ||
          out_sum1 !== e_sum1 || out_ovf0 !== e_ovf0 || out_ovf1 !== e_ovf1) begin
        failures++;
        $display("FAIL %s hold_stable h=%0d: got vld=%b%b sum=%0d/%0d want vld=11 sum=%0d/%0d",
                 name, h, out_valid0, out_valid1, $signed(out_sum0), $signed(out_sum1),
                 $signed(e_sum0), $signed(e_sum1));
      end
    end
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    out_ready = 1'b0;
    checks++;
    if ({out_valid0, out_valid1, busy0, busy1, in_ready0, in_ready1} !== 6'b000000) begin
      failures++;
      $display("FAIL %s release: got vld/busy/rdy=%b want 000000", name,
               {out_valid0, out_valid1, busy0, busy1, in_ready0, in_ready1});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({in_ready0, out_valid0, out_sum0, out_ovf0, busy0,
         in_ready1, out_valid1, out_sum1, out_ovf1, busy1} !== 24'd0) begin
      failures++;
      $display("FAIL reset_state: got %h want 0", {in_ready0, out_valid0, out_sum0, out_ovf0,
               busy0, in_ready1, out_valid1, out_sum1, out_ovf1, busy1});
    end
    reset = 1'b0;
  endtask

  task automatic test_basic_sum();
    op_buf[0] = 2; op_buf[1] = 3;
    run_job("basic_sum", 2, 0, 0, 1'b0);
  endtask

  task automatic test_mixed_signs();
    op_buf[0] = 4; op_buf[1] = -5; op_buf[2] = -1;
    run_job("mixed_3", 3, 0, 0, 1'b0);
    op_buf[0] = -1; op_buf[1] = 1;
    run_job("mixed_2", 2, 0, 0, 1'b0);
  endtask

  task automatic test_pos_overflow();
    op_buf[0] = 100; op_buf[1] = 50;
    run_job("pos_ovf", 2, 0, 0, 1'b0);
    op_buf[0] = 127; op_buf[1] = 127; op_buf[2] = -1;
    run_job("pos_ovf_sticky", 3, 0, 0, 1'b0);
  endtask

  task automatic test_neg_overflow();
    op_buf[0] = -70; op_buf[1] = -90;
    run_job("neg_ovf", 2, 0, 0, 1'b0);
    op_buf[0] = -128; op_buf[1] = -128;
    run_job("neg_ovf_min", 2, 0, 0, 1'b0);
  endtask

  task automatic test_handshake();
    op_buf[0] = 40; op_buf[1] = -20;
    vpat = '{1'b1, 1'b0, 1'b0, 1'b1};
    run_job("valid_gaps", 2, 0, 0, 1'b0);
    op_buf[0] = 33; op_buf[1] = -7; op_buf[2] = 90;
    run_job("ready_hold", 3, 0, 3, 1'b1);
    run_job("len_zero", 0, 0, 0, 1'b0);
    run_job("len_zero_hold", 0, 0, 2, 1'b1);
  endtask

  task automatic test_reset_mid_job();
    @(negedge clock);
    start = 1'b1;
    len = COUNT_W'(3);
    @(negedge clock);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'd50;
    @(negedge clock);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({in_ready0, out_valid0, out_sum0, out_ovf0, busy0,
         in_ready1, out_valid1, out_sum1, out_ovf1, busy1} !== 24'd0) begin
      failures++;
      $display("FAIL reset_mid_job: got %h want 0", {in_ready0, out_valid0, out_sum0, out_ovf0,
               busy0, in_ready1, out_valid1, out_sum1, out_ovf1, busy1});
    end
    @(negedge clock);
    reset = 1'b0;
    op_buf[0] = -40;
    run_job("after_reset", 1, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 16; i++) op_buf[i] = $urandom_range(255) - 128;
      run_job("back_to_back", $urandom_range(1, 5), 0, 0, 1'b0);
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 40; j++) begin
      for (int i = 0; i < 16; i++) op_buf[i] = $urandom_range(255) - 128;
      run_job("random", $urandom_range(0, 15), $urandom_range(0, 50),
              $urandom_range(0, 3), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_mixed_signs();
    test_pos_overflow();
    test_neg_overflow();
    test_handshake();
    test_reset_mid_job();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_accum_ctrl.md
# adder_accum_ctrl

Sequencing controller for the 8-bit signed adder datapath in the MAC block. Accepts a job of `len` signed 8-bit operands over a valid/ready input stream. Accumulates them into an 8-bit register through one internal `adder8` instance, and returns the sum and a sticky overflow flag over a valid/ready output stream. It is the accumulate stage that sits between the operand source (multiplier output or test driver) and the MAC result consumer.

## Interface
- `COUNT_W`, 4: width of `len` and of the internal beat counter; max job length 2^COUNT_W−1.
- `SATURATE`, 0: 0 = two's-complement wrap on overflow; 1 = clamp to +127/−128 on overflow.
- `clock`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  job request; sampled only in IDLE.
- `len`  in  COUNT_W  operand count for the job, latched with `start`.
- `in_valid`  in  1  operand valid.
- `in_data`  in  8  signed operand.
- `in_ready`  out  1  controller can accept an operand.
- `out_valid`  out  1  result valid.
- `out_sum`  out  8  signed accumulated result.
- `out_ovf`  out  1  sticky signed-overflow flag for the job.
- `out_ready`  in  1  consumer accepts the result.
- `busy`  out  1  high in ACCUM and DONE.

## Operation
- FSM states are IDLE, ACCUM and DONE. All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.
- **IDLE**
  - `in_ready`=0, `out_valid`=0, `busy`=0.
  - On `start`=1 the block latches `len` into the counter, clears `acc` and `ovf`, then goes to ACCUM.
  - If `len`=0, it goes directly to DONE with sum 0 and ovf 0.
- **ACCUM**
  - `in_ready`=1.
  - A handshake is `in_valid`&&`in_ready`. On each handshake: `acc`←`adder8(A=acc, B=in_data)`, and the counter decrements.
  - `in_valid`=0 cycles are bubbles. On a bubble, `acc` and the counter hold.
  - The handshake that brings the counter to 0 moves the FSM to DONE.
- **DONE**
  - `out_valid`=1, `out_sum`=`acc`, `out_ovf`=`ovf`. These hold stable until `out_ready`=1.
  - The FSM goes to IDLE on the edge where `out_valid`&&`out_ready`.
- **Overflow detection:** overflow occurs when `acc[7]`==`in_data[7]` and `raw_sum[7]`!=`acc[7]`. On overflow, `ovf`←1. Once set, `ovf` is sticky until the next accepted `start`.
- **SATURATE=1:** on overflow, `acc`←+127 (0x7F) if `in_data[7]`=0, otherwise −128 (0x80). Later operands add to the clamped value.
- **SATURATE=0:** `acc`←`raw_sum` (wraps).
- **`start` outside IDLE:** ignored, with no effect on the running job.
- **`in_valid` outside ACCUM:** ignored. `in_ready`=0, so no operand is consumed.
- **Reset values** (async, effective immediately, including mid-job): state=IDLE, `acc`=0, `ovf`=0, counter=0. Resulting outputs: `in_ready`=0, `out_valid`=0, `out_sum`=0, `out_ovf`=0, `busy`=0. Any partial job is discarded.

## Timing
- `start` is sampled at edge E0. `in_ready` is high from the cycle after E0.
- With `in_valid` held high, operand k (k=1..L) is consumed at edge E0+k.
- `out_valid` rises after edge E0+L. Minimum latency from start to result is L+1 cycles.
- For `len`=0, `out_valid` rises after E0 (1 cycle).
- If `out_ready` is already high when `out_valid` rises, DONE lasts exactly 1 cycle.
- The next `start` can be sampled at the edge after the return to IDLE. Back-to-back job overhead is 2 cycles (DONE + IDLE).
- The adder path is single-cycle: `acc`→`adder8`→overflow/saturation mux→`acc`.

## Test plan
- **Basic sum:** `len`=2, operands 2, 3, `out_ready`=1 → `out_sum`=5, `out_ovf`=0. `out_valid` is high for exactly 1 cycle, 3 cycles after the start edge.
- **Mixed signs:** `len`=3, operands 4, −5, −1 → `out_sum`=−2 (0xFE), `out_ovf`=0.
  - `len`=2, operands −1, 1 → 0.
- **Positive overflow:** `len`=2, operands 100, 50.
  - SATURATE=0 → `out_sum`=−106 (0x96), `out_ovf`=1.
  - SATURATE=1 → 127, `out_ovf`=1.
  - With SATURATE=1 and operands 127, 127, −1 → 126, `out_ovf`=1 (sticky).
- **Negative overflow:** `len`=2, operands −70, −90.
  - SATURATE=0 → 96, `out_ovf`=1.
  - SATURATE=1 → −128, `out_ovf`=1.
  - −128 + −128 → SATURATE=0 → 0, `out_ovf`=1.
- **Handshake stress:**
  - `in_valid` toggles 1,0,0,1 with `len`=2, operands 40, −20 → 20, consumed only on valid cycles.
  - `out_ready` held low for 3 cycles → `out_valid` and `out_sum` stay stable.
  - `start` pulses during ACCUM and DONE → ignored.
  - `len`=0 → result 0 one cycle after start.
- **Reset mid-job:** `len`=3; assert `reset` after 1 operand (50) → all outputs 0 immediately and state is IDLE. A new job with `len`=1, operand −40 → `out_sum`=−40, `out_ovf`=0.
